// File: rtl/sdf_var_delay_line.sv
// Runtime-configurable complex delay line (2^cur_log2 enabled cycles) for the radix-4 SDF FFT.
// Optional fill_count/primed outputs are built when SDF_DELAY_FILL_COUNT_EN is defined.
module sdf_var_delay_line #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_LOG2 = 5,
    parameter int unsigned LOG2_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [LOG2_W-1:0] log2_depth,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  input_real,
    input  logic [WIDTH-1:0]  input_imag,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_real,
    output logic [WIDTH-1:0]  out_imag,
    output logic [LOG2_W-1:0] cur_log2
`ifdef SDF_DELAY_FILL_COUNT_EN
    ,
    output logic [MAX_LOG2:0] fill_count,
    output logic              primed
`endif
);

    localparam int unsigned DEPTH_MAX = 1 << MAX_LOG2;
    localparam int unsigned PTR_W     = MAX_LOG2;

    logic [LOG2_W-1:0]    cur_log2_q;
    logic [PTR_W-1:0]     wptr_q;
    logic [PTR_W-1:0]     wptr_next;
    logic [PTR_W-1:0]     ptr_mask;
    logic [DEPTH_MAX-1:0] valid_q;
    logic [WIDTH-1:0]     mem_re [DEPTH_MAX];
    logic [WIDTH-1:0]     mem_im [DEPTH_MAX];

    logic [LOG2_W-1:0]    log2_clamped;
    logic                 cfg_change;
    logic                 wr_en;
    logic                 rd_valid;

    always_comb begin
        log2_clamped = log2_depth;
        if (log2_depth > LOG2_W'(MAX_LOG2)) begin
            log2_clamped = LOG2_W'(MAX_LOG2);
        end
    end

    // A depth change takes priority over a write; the sample on that edge is dropped.
    assign cfg_change = (log2_clamped != cur_log2_q);
    assign wr_en      = enable & ~cfg_change;

    // Mask of D-1: the pointer wraps at the active depth, not at the storage size.
    assign ptr_mask  = ~({PTR_W{1'b1}} << cur_log2_q);
    assign wptr_next = (wptr_q + PTR_W'(1)) & ptr_mask;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_log2_q <= '0;
            wptr_q     <= '0;
            valid_q    <= '0;
        end else if (cfg_change) begin
            cur_log2_q <= log2_clamped;
            wptr_q     <= '0;
            valid_q    <= '0;
        end else if (enable) begin
            valid_q[wptr_q] <= in_valid;
            wptr_q          <= wptr_next;
        end
    end

    // Sample storage carries no reset; the valid tags alone decide what is visible.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_re[wptr_q] <= input_real;
            mem_im[wptr_q] <= input_imag;
        end
    end

    always_comb begin
        rd_valid = valid_q[wptr_q] & ~cfg_change;
        out_real = '0;
        out_imag = '0;
        if (rd_valid) begin
            out_real = mem_re[wptr_q];
            out_imag = mem_im[wptr_q];
        end
    end

    assign out_valid = rd_valid;
    assign cur_log2  = cur_log2_q;

`ifdef SDF_DELAY_FILL_COUNT_EN
    localparam int unsigned CNT_W = MAX_LOG2 + 1;

    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] depth_val;

    assign depth_val = CNT_W'(1) << cur_log2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_q <= '0;
        end else if (cfg_change) begin
            fill_q <= '0;
        end else if (enable && (fill_q != depth_val)) begin
            fill_q <= fill_q + CNT_W'(1);
        end
    end

    assign fill_count = fill_q;
    assign primed     = (fill_q == depth_val);
`endif

endmodule

// File: tb/tb_sdf_var_delay_line.sv
// Directed bench for sdf_var_delay_line: a vector table for the first depth run, then
// model-checked sequences for reconfiguration, enable gaps, clamping, wrap and async reset.
module tb_sdf_var_delay_line;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [2:0]  log2_depth;
    logic        in_valid;
    logic [31:0] input_real;
    logic [31:0] input_imag;
    logic        out_valid;
    logic [31:0] out_real;
    logic [31:0] out_imag;
    logic [2:0]  cur_log2;
`ifdef SDF_DELAY_FILL_COUNT_EN
    logic [5:0]  fill_count;
    logic        primed;
`endif

    sdf_var_delay_line #(
        .WIDTH    (32),
        .MAX_LOG2 (5),
        .LOG2_W   (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .log2_depth (log2_depth),
        .in_valid   (in_valid),
        .input_real (input_real),
        .input_imag (input_imag),
        .out_valid  (out_valid),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .cur_log2   (cur_log2)
`ifdef SDF_DELAY_FILL_COUNT_EN
        ,
        .fill_count (fill_count),
        .primed     (primed)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [2:0]  l2;
        logic        iv;
        logic [31:0] re;
        logic [31:0] im;
        logic        ev;
        logic [31:0] er;
        logic [31:0] ei;
        logic [2:0]  ec;
    } vec_t;

    int n_pass;
    int n_checks;

    // Latency model: after n writes the output is write n-D (0-based) once n >= D.
    logic [31:0] hist_re [256];
    logic        hist_v  [256];
    int          wr_n;
    int          d_cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic en, input logic [2:0] l2, input logic iv,
                                input int re, input int im, input logic ev, input int er,
                                input int ei, input logic [2:0] ec);
        vec_t v;
        v.en = en; v.l2 = l2; v.iv = iv; v.re = re; v.im = im;
        v.ev = ev; v.er = er; v.ei = ei; v.ec = ec;
        return v;
    endfunction

    task automatic configure(input int l2);
        int cl;
        cl = (l2 > 5) ? 5 : l2;
        enable     = 1'b0;
        log2_depth = 3'(l2);
        step();
        d_cur = 1 << cl;
        wr_n  = 0;
        chk("cfg_cur_log2", 64'(cur_log2), 64'(cl));
        chk("cfg_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic feed(input int n, input int base, input bit gaps, input bit holes,
                        input string tag);
        logic        ev;
        logic [31:0] er;
        logic [31:0] ei;
        for (int i = 0; i < n; i++) begin
            enable     = gaps ? (i % 2 == 0) : 1'b1;
            input_real = 32'(base + i);
            input_imag = ~32'(base + i);
            in_valid   = holes ? ((base + i) % 7 != 0) : 1'b1;
            step();
            if (enable) begin
                hist_re[wr_n] = input_real;
                hist_v[wr_n]  = in_valid;
                wr_n++;
            end
            ev = 1'b0; er = '0; ei = '0;
            if (wr_n >= d_cur && hist_v[wr_n - d_cur]) begin
                ev = 1'b1;
                er = hist_re[wr_n - d_cur];
                ei = ~hist_re[wr_n - d_cur];
            end
            chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
            chk({tag, "_real"}, 64'(out_real), 64'(er));
            chk({tag, "_imag"}, 64'(out_imag), 64'(ei));
        end
    endtask

    vec_t tbl [18];

    initial begin
        n_pass = 0; n_checks = 0; wr_n = 0; d_cur = 1;
        reset = 1'b1; enable = 1'b0; log2_depth = 3'd0; in_valid = 1'b0;
        input_real = '0; input_imag = '0;

        // Depth 4 from reset: four-write latency, enable hold, in_valid=0 gating.
        tbl[0]  = mk(0, 2, 1, 0,  0,  0, 0,  0,  2);
        tbl[1]  = mk(1, 2, 1, 1,  51, 0, 0,  0,  2);
        tbl[2]  = mk(1, 2, 1, 2,  52, 0, 0,  0,  2);
        tbl[3]  = mk(1, 2, 1, 3,  53, 0, 0,  0,  2);
        tbl[4]  = mk(1, 2, 1, 4,  54, 1, 1,  51, 2);
        tbl[5]  = mk(1, 2, 1, 5,  55, 1, 2,  52, 2);
        tbl[6]  = mk(1, 2, 1, 6,  56, 1, 3,  53, 2);
        tbl[7]  = mk(1, 2, 1, 7,  57, 1, 4,  54, 2);
        tbl[8]  = mk(1, 2, 1, 8,  58, 1, 5,  55, 2);
        tbl[9]  = mk(1, 2, 1, 9,  59, 1, 6,  56, 2);
        tbl[10] = mk(1, 2, 1, 10, 60, 1, 7,  57, 2);
        tbl[11] = mk(0, 2, 1, 77, 77, 1, 7,  57, 2);
        tbl[12] = mk(1, 2, 1, 11, 61, 1, 8,  58, 2);
        tbl[13] = mk(1, 2, 0, 12, 62, 1, 9,  59, 2);
        tbl[14] = mk(1, 2, 1, 13, 63, 1, 10, 60, 2);
        tbl[15] = mk(1, 2, 1, 14, 64, 1, 11, 61, 2);
        tbl[16] = mk(1, 2, 1, 15, 65, 0, 0,  0,  2);
        tbl[17] = mk(1, 2, 1, 16, 66, 1, 13, 63, 2);

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_real", 64'(out_real), 64'd0);
        chk("rst_cur_log2", 64'(cur_log2), 64'd0);
        #10 reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            enable     = tbl[i].en;
            log2_depth = tbl[i].l2;
            in_valid   = tbl[i].iv;
            input_real = tbl[i].re;
            input_imag = tbl[i].im;
            step();
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_real", i), 64'(out_real), 64'(tbl[i].er));
            chk($sformatf("tbl%0d_imag", i), 64'(out_imag), 64'(tbl[i].ei));
            chk($sformatf("tbl%0d_cur", i), 64'(cur_log2), 64'(tbl[i].ec));
        end

        // Reconfigure to depth 8 while enabled: output gated at once, sample 999 lost.
        enable = 1'b1; log2_depth = 3'd3; in_valid = 1'b1;
        input_real = 32'd999; input_imag = 32'd999;
        #1;
        chk("mismatch_valid", 64'(out_valid), 64'd0);
        chk("mismatch_real", 64'(out_real), 64'd0);
        step();
        chk("reconf_cur", 64'(cur_log2), 64'd3);
        d_cur = 8; wr_n = 0;
        feed(12, 200, 1'b0, 1'b0, "reconf");

        configure(0);
        feed(5, 300, 1'b0, 1'b0, "d1");

        configure(3);
        feed(20, 1, 1'b1, 1'b0, "gaps");

        configure(7);
        feed(100, 1000, 1'b0, 1'b1, "clamp");

        // Async reset between edges with the depth-16 line half full.
        configure(4);
        feed(8, 500, 1'b0, 1'b0, "pre_rst");
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_real", 64'(out_real), 64'd0);
        chk("arst_imag", 64'(out_imag), 64'd0);
        chk("arst_cur", 64'(cur_log2), 64'd0);
        #1 reset = 1'b0;
        configure(4);
        feed(20, 600, 1'b0, 1'b0, "post_rst");

`ifdef SDF_DELAY_FILL_COUNT_EN
        configure(2);
        chk("fill_init", 64'(fill_count), 64'd0);
        for (int i = 1; i <= 6; i++) begin
            enable = 1'b1; in_valid = 1'b1; input_real = 32'(i); input_imag = 32'(i);
            step();
            chk($sformatf("fill_%0d", i), 64'(fill_count), 64'((i > 4) ? 4 : i));
            chk($sformatf("primed_%0d", i), 64'(primed), 64'(i >= 4));
        end
        configure(1);
        chk("fill_clr", 64'(fill_count), 64'd0);
        chk("primed_clr", 64'(primed), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
